madd_err_accum: RTL
===================

Name: madd_err_accum

Overview:
- Downstream error-evaluation stage for the 6x6+6 multiply-add circuits, exact or approximate.
- Takes each operand triple (a, b, c) and the 12-bit result produced by the circuit under test.
- Recomputes the exact result a*b+c internally and accumulates error statistics over a programmed number of samples.
- Reports mean-error inputs: error count, sum of absolute error, signed error sum and maximum absolute error.

Parameters:
W_IN, 6, operand width of a, b, c
W_OUT, 12, result width; must satisfy W_OUT >= 2*W_IN
CNT_W, 16, width of sample target and sample/error counters
ACC_W, 32, width of absolute and signed error accumulators

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a campaign; sampled only in IDLE or DONE
sample_target  in  CNT_W  number of samples for the campaign, latched on start
in_valid  in  1  operand/result sample valid
in_ready  out  1  block accepts a sample this cycle
a  in  W_IN  operand a
b  in  W_IN  operand b
c  in  W_IN  addend c
approx  in  W_OUT  result from the circuit under test
busy  out  1  campaign in progress (RUN or DRAIN)
done  out  1  one-cycle pulse on entry to DONE
samples  out  CNT_W  samples accumulated
err_count  out  CNT_W  samples with nonzero error
sum_abs  out  ACC_W  sum of |approx-exact|, saturating
sum_signed  out  ACC_W  two's-complement sum of (approx-exact), wrapping
max_abs  out  W_OUT+1  largest |approx-exact| seen

Behaviour:
- Reset: state IDLE, all outputs 0, both pipeline valid flags 0.
- Reset mid-campaign aborts immediately. Nothing in flight is committed.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - Latch sample_target and clear all statistics and the issue counter.
  - If target != 0, go to RUN.
  - If target == 0, go to DONE next cycle; done pulses with all statistics 0.
- RUN:
  - in_ready = 1 while issued < target.
  - A sample is accepted when in_valid & in_ready; issued increments.
  - When the final sample is accepted, in_ready drops the next cycle and state moves to DRAIN.
- DRAIN: wait until both pipeline stages are empty, then go to DONE.
- DONE:
  - done = 1 for the entry cycle only.
  - Statistics hold until the next start or rst.
  - start in DONE behaves as start in IDLE.
- start in RUN or DRAIN is ignored. in_valid outside RUN is ignored.
- in_ready = 0 in IDLE, DRAIN and DONE.
- Pipeline stage 1 (registered on acceptance):
  - exact = a*b + c, zero-extended to W_OUT bits (no overflow for W_OUT >= 2*W_IN).
  - diff = approx - exact as a signed W_OUT+1 value.
- Pipeline stage 2 (registered):
  - samples += 1.
  - err_count += (diff != 0).
  - sum_abs += |diff|, saturating at all-ones.
  - sum_signed += sign-extended diff, wrapping.
  - max_abs = max(max_abs, |diff|).
- Latency: a sample accepted at edge t appears in the statistics at edge t+2. Back-to-back acceptance sustains 1 sample/cycle.
- done asserts no earlier than the cycle after the final sample is reflected in the statistics; busy deasserts in the same cycle.
- Statistics outputs are registered and may be read at any time. Mid-campaign values are partial.

Test Plan:
- Exact match: target=1, a=3 b=5 c=7 approx=22 -> done; samples=1, err_count=0, sum_abs=0, sum_signed=0, max_abs=0.
- Positive/negative error: target=2:
  - sample 1: a=3 b=5 c=7 approx=30 (+8).
  - sample 2: a=63 b=63 c=63 approx=0 (-4032).
  - -> err_count=2, sum_abs=4040, sum_signed=-4024, max_abs=4032.
- Zero target: start with target=0 -> in_ready never 1; done pulses 1 cycle after start; all statistics 0.
- Sample limit: target=3, in_valid held high for 6 cycles with a=1 b=1 c=0 approx=2:
  - exactly 3 samples accepted; in_ready low from the 4th cycle.
  - samples=3, err_count=3, sum_abs=3, done pulse once.
- Gapped valid / ignored start: target=4, in_valid toggling 1,0,1,0,..., start pulsed during RUN -> start ignored; 4 samples counted; done arrives 2 cycles after the last acceptance plus the DRAIN exit.
- Reset mid-run: target=10, assert rst after 5 acceptances -> next cycle all outputs 0, state IDLE. A new start with target=1 behaves as a fresh campaign.

Source files
------------

// File: rtl/madd_err_accum.sv
// Error-statistics accumulator for a*b+c multiply-add circuits under test.
// It recomputes the exact result for each sample and accumulates error counts, sums and the maximum.
module madd_err_accum #(
  parameter int W_IN  = 6,
  parameter int W_OUT = 12,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        sample_target,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W_IN-1:0]         a,
  input  logic [W_IN-1:0]         b,
  input  logic [W_IN-1:0]         c,
  input  logic [W_OUT-1:0]        approx,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        samples,
  output logic [CNT_W-1:0]        err_count,
  output logic [ACC_W-1:0]        sum_abs,
  output logic [ACC_W-1:0]        sum_signed,
  output logic [W_OUT:0]          max_abs
);

  // state | meaning
  // IDLE  | waiting for start, statistics zero
  // RUN   | accepting samples until issued == target
  // DRAIN | all samples issued, waiting for the pipeline to empty
  // DONE  | statistics final and held, done pulsed on entry
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic               launch, accept;
  logic [CNT_W-1:0]   target, issued;
  logic               v1, v2;
  logic signed [W_OUT:0] diff1, diff2, diff_c;
  logic [W_OUT:0]     abs2, abs_c;
  logic [W_OUT-1:0]   exact;
  logic [ACC_W:0]     sum_abs_ext;

  assign in_ready = (state == S_RUN) && (issued < target);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == S_RUN) || (state == S_DRAIN);

  // W_OUT >= 2*W_IN, so the exact result never overflows
  assign exact  = W_OUT'(a) * W_OUT'(b) + W_OUT'(c);
  assign diff_c = $signed({1'b0, approx}) - $signed({1'b0, exact});
  assign abs_c  = diff1[W_OUT] ? $unsigned(-diff1) : $unsigned(diff1);
  assign sum_abs_ext = {1'b0, sum_abs} + {{(ACC_W-W_OUT){1'b0}}, abs2};

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = (sample_target == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept && (issued == target - CNT_W'(1))) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!v1 && !v2) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      done       <= 1'b0;
      target     <= '0;
      issued     <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      diff1      <= '0;
      diff2      <= '0;
      abs2       <= '0;
      samples    <= '0;
      err_count  <= '0;
      sum_abs    <= '0;
      sum_signed <= '0;
      max_abs    <= '0;
    end else begin
      state <= state_nxt;
      // a restart from DONE re-enters DONE, so it must still pulse
      done  <= (state_nxt == S_DONE) && ((state != S_DONE) || launch);

      v1 <= accept;
      if (accept) diff1 <= diff_c;
      v2 <= v1;
      if (v1) begin
        diff2 <= diff1;
        abs2  <= abs_c;
      end

      if (launch) begin
        target     <= sample_target;
        issued     <= '0;
        samples    <= '0;
        err_count  <= '0;
        sum_abs    <= '0;
        sum_signed <= '0;
        max_abs    <= '0;
      end else begin
        if (accept) issued <= issued + CNT_W'(1);
        if (v2) begin
          samples <= samples + CNT_W'(1);
          if (diff2 != '0) err_count <= err_count + CNT_W'(1);
          sum_abs    <= sum_abs_ext[ACC_W] ? '1 : sum_abs_ext[ACC_W-1:0];
          sum_signed <= sum_signed + {{(ACC_W-W_OUT-1){diff2[W_OUT]}}, diff2};
          if (abs2 > max_abs) max_abs <= abs2;
        end
      end
    end
  end

endmodule
